// File: rtl/mips_harness_pkg.sv
// Shared state encoding, error codes and width helper for the MIPS run harness.
package mips_harness_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_RUN  = 3'd2,
    ST_DUMP = 3'd3,
    ST_DONE = 3'd4,
    ST_ERR  = 3'd5
  } state_e;

  localparam logic [1:0] ERR_NONE     = 2'b00;
  localparam logic [1:0] ERR_TIMEOUT  = 2'b01;
  localparam logic [1:0] ERR_OVERFLOW = 2'b10;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/mips_dump_seq.sv
// Data-memory readback sequencer: walks the DUMP_ADDRS list onto a valid/ready
// stream, holding each word until accepted; pulses last_o on the final handshake.
module mips_dump_seq
  import mips_harness_pkg::*;
#(
  parameter int                          DATA_W     = 32,
  parameter int                          DMEM_AW    = 8,
  parameter int                          NUM_DUMP   = 3,
  parameter logic [NUM_DUMP*DMEM_AW-1:0] DUMP_ADDRS = {8'd16, 8'd4, 8'd1},
  parameter int                          IDX_W      = clog2(NUM_DUMP + 1)
) (
  input  logic               clk,
  input  logic               clr,
  input  logic               start_i,
  output logic [DMEM_AW-1:0] dmem_raddr_o,
  input  logic [DATA_W-1:0]  dmem_rdata_i,
  output logic               dump_valid_o,
  input  logic               dump_ready_i,
  output logic [DATA_W-1:0]  dump_data_o,
  output logic [IDX_W-1:0]   dump_idx_o,
  output logic               last_o
);

  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DUMP - 1);

  logic             active_q, active_d;
  logic [IDX_W-1:0] idx_q, idx_d;

  always_ff @(posedge clk) begin
    if (clr) begin
      active_q <= 1'b0;
      idx_q    <= '0;
    end else begin
      active_q <= active_d;
      idx_q    <= idx_d;
    end
  end

  always_comb begin
    active_d = active_q;
    idx_d    = idx_q;
    last_o   = 1'b0;
    if (start_i) begin
      active_d = 1'b1;
      idx_d    = '0;
    end else if (active_q && dump_ready_i) begin
      if (idx_q == IDX_LAST) begin
        active_d = 1'b0;
        idx_d    = '0;
        last_o   = 1'b1;
      end else begin
        idx_d = idx_q + 1'b1;
      end
    end
  end

  // Read port is combinational and memory is static after fin, so the word
  // stays stable for as long as the index is held.
  assign dmem_raddr_o = DUMP_ADDRS[int'(idx_q) * DMEM_AW +: DMEM_AW];
  assign dump_valid_o = active_q;
  assign dump_data_o  = active_q ? dmem_rdata_i : '0;
  assign dump_idx_o   = idx_q;

endmodule

// File: rtl/mips_run_harness.sv
// Run controller for the MIPS pipeline: load program, run with timeout, dump results.
//  IDLE | waiting for start          LOAD | accepting program words into imem
//  RUN  | core released, timing fin  DUMP | streaming data-memory words out
//  DONE | run complete               ERR  | timeout or imem overflow, core held
module mips_run_harness
  import mips_harness_pkg::*;
#(
  parameter int                          DATA_W     = 32,
  parameter int                          IMEM_AW    = 8,
  parameter int                          DMEM_AW    = 8,
  parameter int                          NUM_DUMP   = 3,
  parameter logic [NUM_DUMP*DMEM_AW-1:0] DUMP_ADDRS = {8'd16, 8'd4, 8'd1},
  parameter int                          TIMEOUT    = 1024,
  localparam int                         CYC_W      = clog2(TIMEOUT + 1),
  localparam int                         IDX_W      = clog2(NUM_DUMP + 1)
) (
  input  logic               clk,
  input  logic               clr,
  input  logic               start,
  input  logic               ld_valid,
  output logic               ld_ready,
  input  logic [DATA_W-1:0]  ld_data,
  input  logic               ld_last,
  output logic               imem_we,
  output logic [IMEM_AW-1:0] imem_addr,
  output logic [DATA_W-1:0]  imem_wdata,
  output logic               cpu_pcclr,
  input  logic               cpu_fin,
  output logic [DMEM_AW-1:0] dmem_raddr,
  input  logic [DATA_W-1:0]  dmem_rdata,
  output logic               dump_valid,
  input  logic               dump_ready,
  output logic [DATA_W-1:0]  dump_data,
  output logic [IDX_W-1:0]   dump_idx,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic [1:0]         err_code,
  output logic [CYC_W-1:0]   run_cycles
);

  localparam logic [IMEM_AW-1:0] PTR_MAX   = '1;
  localparam logic [CYC_W-1:0]   CYC_MAX   = '1;
  localparam logic [CYC_W-1:0]   CYC_LIMIT = CYC_W'(TIMEOUT);

  state_e             state_q, state_d;
  logic [IMEM_AW-1:0] ptr_q, ptr_d;
  logic [CYC_W-1:0]   cyc_q, cyc_d;
  logic [1:0]         ecode_q, ecode_d;
  logic               ld_fire, dump_start, dump_last;

  assign ld_fire = (state_q == ST_LOAD) && ld_valid;

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      cyc_q   <= '0;
      ecode_q <= ERR_NONE;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cyc_q   <= cyc_d;
      ecode_q <= ecode_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    cyc_d      = cyc_q;
    ecode_d    = ecode_q;
    dump_start = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE, ST_ERR: begin
        if (start) begin
          state_d = ST_LOAD;
          ptr_d   = '0;
          cyc_d   = '0;
          ecode_d = ERR_NONE;
        end
      end
      ST_LOAD: begin
        if (ld_fire) begin
          ptr_d = ptr_q + 1'b1;
          if (ld_last) begin
            state_d = ST_RUN;
          end else if (ptr_q == PTR_MAX) begin
            state_d = ST_ERR;
            ecode_d = ERR_OVERFLOW;
            ptr_d   = ptr_q;
          end
        end
      end
      ST_RUN: begin
        if (cyc_q != CYC_MAX) cyc_d = cyc_q + 1'b1;
        // cyc_q == 0 marks the first RUN cycle, when fin is still stale from clear
        if (cpu_fin && (cyc_q != '0)) begin
          state_d    = ST_DUMP;
          dump_start = 1'b1;
        end else if (cyc_d >= CYC_LIMIT) begin
          state_d = ST_ERR;
          ecode_d = ERR_TIMEOUT;
        end
      end
      ST_DUMP: begin
        if (dump_last) state_d = ST_DONE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  mips_dump_seq #(
    .DATA_W    (DATA_W),
    .DMEM_AW   (DMEM_AW),
    .NUM_DUMP  (NUM_DUMP),
    .DUMP_ADDRS(DUMP_ADDRS),
    .IDX_W     (IDX_W)
  ) u_dump (
    .clk         (clk),
    .clr         (clr),
    .start_i     (dump_start),
    .dmem_raddr_o(dmem_raddr),
    .dmem_rdata_i(dmem_rdata),
    .dump_valid_o(dump_valid),
    .dump_ready_i(dump_ready),
    .dump_data_o (dump_data),
    .dump_idx_o  (dump_idx),
    .last_o      (dump_last)
  );

  assign ld_ready   = (state_q == ST_LOAD);
  assign imem_we    = ld_fire;
  assign imem_addr  = ptr_q;
  assign imem_wdata = ld_data;
  assign cpu_pcclr  = (state_q == ST_RUN) || (state_q == ST_DUMP);
  assign busy       = (state_q == ST_LOAD) || (state_q == ST_RUN) || (state_q == ST_DUMP);
  assign done       = (state_q == ST_DONE);
  assign err        = (state_q == ST_ERR);
  assign err_code   = ecode_q;
  assign run_cycles = cyc_q;

endmodule

// File: tb/tb_mips_run_harness.sv
// Scoreboard bench for mips_run_harness (IMEM_AW=3, TIMEOUT=64).
module tb_mips_run_harness;

  localparam int DATA_W  = 32;
  localparam int IMEM_AW = 3;
  localparam int DMEM_AW = 8;
  localparam int DEPTH   = 8;
  localparam int TMO     = 64;

  logic               clk = 1'b0;
  logic               clr = 1'b1;
  logic               start = 1'b0;
  logic               ld_valid = 1'b0;
  logic               ld_ready;
  logic [DATA_W-1:0]  ld_data = '0;
  logic               ld_last = 1'b0;
  logic               imem_we;
  logic [IMEM_AW-1:0] imem_addr;
  logic [DATA_W-1:0]  imem_wdata;
  logic               cpu_pcclr;
  logic               cpu_fin = 1'b0;
  logic [DMEM_AW-1:0] dmem_raddr;
  logic [DATA_W-1:0]  dmem_rdata;
  logic               dump_valid;
  logic               dump_ready = 1'b1;
  logic [DATA_W-1:0]  dump_data;
  logic [1:0]         dump_idx;
  logic               busy, done, err;
  logic [1:0]         err_code;
  logic [6:0]         run_cycles;

  logic [31:0] mem_seed = 32'h1234_5678;

  int n_checks = 0;
  int n_fail   = 0;
  int n_writes = 0;

  int          imem_addr_q[$];
  logic [31:0] imem_data_q[$];
  int          dump_idx_q[$];
  logic [31:0] dump_data_q[$];

  always #5 clk = ~clk;

  function automatic logic [31:0] memval(input logic [31:0] seed, input logic [7:0] a);
    return seed ^ ({24'h0, a} * 32'h9E37_79B1) ^ {a, 24'h0};
  endfunction

  assign dmem_rdata = memval(mem_seed, dmem_raddr);

  mips_run_harness #(
    .IMEM_AW(IMEM_AW),
    .TIMEOUT(TMO)
  ) dut (
    .clk(clk), .clr(clr), .start(start),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_data(ld_data), .ld_last(ld_last),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .cpu_pcclr(cpu_pcclr), .cpu_fin(cpu_fin),
    .dmem_raddr(dmem_raddr), .dmem_rdata(dmem_rdata),
    .dump_valid(dump_valid), .dump_ready(dump_ready), .dump_data(dump_data), .dump_idx(dump_idx),
    .busy(busy), .done(done), .err(err), .err_code(err_code), .run_cycles(run_cycles)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (imem_we) begin
      n_writes++;
      chk("imem_pending", imem_addr_q.size() != 0, 1);
      if (imem_addr_q.size() != 0) begin
        chk("imem_addr", imem_addr, imem_addr_q.pop_front());
        chk("imem_wdata", imem_wdata, imem_data_q.pop_front());
      end
    end
    if (dump_valid && dump_ready) begin
      chk("dump_pending", dump_idx_q.size() != 0, 1);
      if (dump_idx_q.size() != 0) begin
        chk("dump_idx", dump_idx, dump_idx_q.pop_front());
        chk("dump_data", dump_data, dump_data_q.pop_front());
      end
    end
  end

  task automatic check_idle(input string tag);
    chk({tag, "_pcclr"}, cpu_pcclr, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_err"}, err, 0);
    chk({tag, "_ecode"}, err_code, 0);
    chk({tag, "_cyc"}, run_cycles, 0);
    chk({tag, "_dvalid"}, dump_valid, 0);
    chk({tag, "_ldready"}, ld_ready, 0);
  endtask

  // Pulse start, then present n words; words past the imem depth must be refused.
  task automatic load_prog(input int n, input bit last, input bit toggle);
    logic [31:0] d;
    n_writes = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("load_ready", ld_ready, 1);
    chk("load_pcclr", cpu_pcclr, 0);
    chk("load_ecode", err_code, 0);
    chk("load_cyc", run_cycles, 0);
    for (int i = 0; i < n; i++) begin
      if (toggle && i > 0) begin
        ld_valid = 1'b0;
        tick();
      end
      d = $urandom;
      ld_valid = 1'b1;
      ld_data  = d;
      ld_last  = last && (i == n - 1);
      if (i < DEPTH) begin
        imem_addr_q.push_back(i);
        imem_data_q.push_back(d);
      end else begin
        chk("ovf_ready", ld_ready, 0);
      end
      tick();
    end
    ld_valid = 1'b0;
    ld_last  = 1'b0;
    chk("imem_left", imem_addr_q.size(), 0);
  endtask

  task automatic do_run(input int n, input bit toggle, input int fin_at, input bit fin_early,
                        input bit stall);
    int k;
    mem_seed = $urandom;
    load_prog(n, 1'b1, toggle);
    chk("nwrites", n_writes, n);
    chk("run_pcclr", cpu_pcclr, 1);
    for (int c = 1; c < fin_at; c++) begin
      cpu_fin = fin_early;
      start   = (c == 3);
      tick();
    end
    start   = 1'b0;
    cpu_fin = 1'b1;
    dump_idx_q.push_back(0); dump_data_q.push_back(memval(mem_seed, 8'd1));
    dump_idx_q.push_back(1); dump_data_q.push_back(memval(mem_seed, 8'd4));
    dump_idx_q.push_back(2); dump_data_q.push_back(memval(mem_seed, 8'd16));
    tick();
    cpu_fin = 1'b0;
    chk("run_cycles", run_cycles, fin_at);
    chk("dump_lat", dump_valid, 1);
    chk("dump_pcclr", cpu_pcclr, 1);
    chk("dump_busy", busy, 1);
    if (stall) begin
      tick();
      dump_ready = 1'b0;
      for (int s = 0; s < 3; s++) begin
        tick();
        chk("stall_valid", dump_valid, 1);
        chk("stall_idx", dump_idx, 1);
        chk("stall_data", dump_data, memval(mem_seed, 8'd4));
      end
      dump_ready = 1'b1;
    end
    k = 0;
    while (!done && k < 20) begin
      tick();
      k++;
    end
    chk("done", done, 1);
    chk("dump_left", dump_idx_q.size(), 0);
    chk("done_pcclr", cpu_pcclr, 0);
    chk("done_busy", busy, 0);
    chk("done_dvalid", dump_valid, 0);
    chk("done_cyc_held", run_cycles, fin_at);
  endtask

  initial begin
    int n;
    repeat (3) tick();
    check_idle("rst");
    clr = 1'b0;
    tick();
    check_idle("idle");

    do_run(5, 1'b0, 20, 1'b0, 1'b0);
    do_run(6, 1'b1, 2, 1'b1, 1'b0);
    do_run(3, 1'b0, TMO, 1'b0, 1'b1);

    // timeout: fin never comes
    load_prog(2, 1'b1, 1'b0);
    n = 0;
    while (cpu_pcclr && n < 200) begin
      tick();
      n++;
    end
    chk("tmo_run_len", n, TMO);
    chk("tmo_err", err, 1);
    chk("tmo_code", err_code, 2'b01);
    chk("tmo_cyc", run_cycles, TMO);
    repeat (3) tick();
    chk("tmo_sticky", err, 1);
    chk("tmo_sticky_code", err_code, 2'b01);

    // overflow: nine words into an eight-word imem
    load_prog(9, 1'b0, 1'b0);
    chk("ovf_writes", n_writes, DEPTH);
    chk("ovf_err", err, 1);
    chk("ovf_code", err_code, 2'b10);
    chk("ovf_pcclr", cpu_pcclr, 0);
    chk("ovf_ready_after", ld_ready, 0);

    // clr during RUN
    load_prog(3, 1'b1, 1'b0);
    repeat (5) tick();
    chk("clrrun_pcclr_before", cpu_pcclr, 1);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    check_idle("clrrun");

    // clr during a stalled DUMP
    dump_ready = 1'b0;
    load_prog(3, 1'b1, 1'b0);
    repeat (3) tick();
    cpu_fin = 1'b1;
    tick();
    cpu_fin = 1'b0;
    tick();
    chk("clrdump_valid_before", dump_valid, 1);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    check_idle("clrdump");
    chk("clrdump_idx", dump_idx, 0);
    dump_ready = 1'b1;

    do_run(4, 1'b0, 7, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
